// File: rtl/arith_result_stage.sv
// ---------------------------------------------------------------------------
// arith_result_stage
//
// Purpose:
//   Captures arithmetic results from an upstream ALU into a small FIFO,
//   decorates each entry with derived status flags (zero, negative) next to
//   the flags supplied by the ALU (overflow, carry-out), and presents the
//   oldest entry to a downstream consumer through a valid/ready handshake.
//   A sticky overflow bit records that any accepted result overflowed since
//   the last clear.
//
// Ports:
//   clk_i        - single clock, all state updates on its rising edge
//   rst_n_i      - asynchronous active-low reset
//   valid_i      - upstream result valid
//   ready_o      - stage can accept a result (not full)
//   result_i     - N-bit arithmetic result
//   overflow_i   - arithmetic overflow flag
//   cout_i       - arithmetic carry-out flag
//   opcode_i     - opcode that produced the result
//   valid_o      - head entry valid (not empty)
//   ready_i      - downstream accepts the head entry
//   result_o     - head result
//   flags_o      - head flags {zero, negative, overflow, cout}
//   opcode_o     - head opcode
//   count_o      - current occupancy, 0..DEPTH
//   sticky_ovf_o - an accepted result overflowed since the last clear
//   clear_i      - synchronous clear of sticky_ovf_o
// ---------------------------------------------------------------------------
module arith_result_stage #(
   parameter int N     = 16,
   parameter int DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic                       valid_i,
   output logic                       ready_o,
   input  logic [N-1:0]               result_i,
   input  logic                       overflow_i,
   input  logic                       cout_i,
   input  logic [2:0]                 opcode_i,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic [N-1:0]               result_o,
   output logic [3:0]                 flags_o,
   output logic [2:0]                 opcode_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       sticky_ovf_o,
   input  logic                       clear_i
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   // Entry layout: {opcode[2:0], flags[3:0], result[N-1:0]}
   localparam int EW = N + 7;

   logic [EW-1:0] mem_reg [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          sticky_reg;

   logic          push;
   logic          pop;
   logic [3:0]    flags_next;
   logic [EW-1:0] entry_next;
   logic [EW-1:0] head_entry;

   // Handshake status comes only from occupancy, so ready_o never depends
   // on ready_i combinationally.
   assign ready_o = (count_reg != CW'(DEPTH));
   assign valid_o = (count_reg != '0);
   assign push    = valid_i & ready_o;
   assign pop     = valid_o & ready_i;

   assign flags_next = {(result_i == '0), result_i[N-1], overflow_i, cout_i};
   assign entry_next = {opcode_i, flags_next, result_i};

   // Storage is not reset; the head is gated with valid_o below so that
   // uninitialised contents never leak onto the outputs.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_reg[wr_ptr_reg] <= entry_next;
      end
   end

   // DEPTH is a power of two, so pointers wrap modulo DEPTH naturally.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         sticky_reg <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
         // An overflowing push in the same cycle as a clear wins.
         if (push && overflow_i) begin
            sticky_reg <= 1'b1;
         end else if (clear_i) begin
            sticky_reg <= 1'b0;
         end
      end
   end

   assign head_entry   = valid_o ? mem_reg[rd_ptr_reg] : '0;
   assign result_o     = head_entry[N-1:0];
   assign flags_o      = head_entry[N+3:N];
   assign opcode_o     = head_entry[N+6:N+4];
   assign count_o      = count_reg;
   assign sticky_ovf_o = sticky_reg;

endmodule

// File: tb/tb_arith_result_stage.sv
// ---------------------------------------------------------------------------
// tb_arith_result_stage
//
// Purpose:
//   Self-checking bench for arith_result_stage (N=16, DEPTH=4). Directed
//   sequences (some table-driven) cover the handshake corner cases, then a
//   randomized phase runs against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_arith_result_stage;

   localparam int N     = 16;
   localparam int DEPTH = 4;

   logic          clk_i = 1'b0;
   logic          rst_n_i;
   logic          valid_i;
   logic          ready_o;
   logic [N-1:0]  result_i;
   logic          overflow_i;
   logic          cout_i;
   logic [2:0]    opcode_i;
   logic          valid_o;
   logic          ready_i;
   logic [N-1:0]  result_o;
   logic [3:0]    flags_o;
   logic [2:0]    opcode_o;
   logic [2:0]    count_o;
   logic          sticky_ovf_o;
   logic          clear_i;

   arith_result_stage #(.N(N), .DEPTH(DEPTH)) dut (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .valid_i      (valid_i),
      .ready_o      (ready_o),
      .result_i     (result_i),
      .overflow_i   (overflow_i),
      .cout_i       (cout_i),
      .opcode_i     (opcode_i),
      .valid_o      (valid_o),
      .ready_i      (ready_i),
      .result_o     (result_o),
      .flags_o      (flags_o),
      .opcode_o     (opcode_o),
      .count_o      (count_o),
      .sticky_ovf_o (sticky_ovf_o),
      .clear_i      (clear_i)
   );

   always #5 clk_i = ~clk_i;

   // ---------------- reference model ----------------
   typedef struct {
      logic [N-1:0] res;
      logic         ovf;
      logic         cout;
      logic [2:0]   op;
   } ent_t;

   ent_t mq[$];
   bit   m_sticky;

   int checks = 0;
   int passed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [3:0] exp_flags(input ent_t e);
      return {(e.res == 0), e.res[N-1], e.ovf, e.cout};
   endfunction

   task automatic compare_model();
      chk("count", 32'(count_o), 32'(mq.size()));
      chk("valid", 32'(valid_o), 32'(mq.size() != 0));
      chk("ready", 32'(ready_o), 32'(mq.size() != DEPTH));
      chk("sticky", 32'(sticky_ovf_o), 32'(m_sticky));
      if (mq.size() != 0) begin
         chk("result", 32'(result_o), 32'(mq[0].res));
         chk("flags", 32'(flags_o), 32'(exp_flags(mq[0])));
         chk("opcode", 32'(opcode_o), 32'(mq[0].op));
      end
   endtask

   // Applies the current inputs for one clock, advances the model, and
   // compares at the following falling edge.
   task automatic step();
      bit   push, pop;
      ent_t e;
      push  = valid_i && (mq.size() != DEPTH);
      pop   = ready_i && (mq.size() != 0);
      e.res = result_i; e.ovf = overflow_i; e.cout = cout_i; e.op = opcode_i;
      @(posedge clk_i);
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(e);
      if (push && overflow_i) m_sticky = 1'b1;
      else if (clear_i) m_sticky = 1'b0;
      @(negedge clk_i);
      $display("t=%0t push=%0d pop=%0d res_in=%h cnt=%0d head=%h flags=%b sticky=%0d",
               $time, push, pop, e.res, count_o, result_o, flags_o, sticky_ovf_o);
      compare_model();
   endtask

   task automatic drive(input bit v, input bit r, input logic [N-1:0] res,
                        input bit ovf, input bit co, input logic [2:0] op, input bit clr);
      valid_i = v; ready_i = r; result_i = res;
      overflow_i = ovf; cout_i = co; opcode_i = op; clear_i = clr;
   endtask

   task automatic drain();
      drive(0, 1, 16'h0, 0, 0, 3'd0, 0);
      for (int i = 0; i < DEPTH + 1; i++) step();
   endtask

   // ---------------- fill/drain vector table ----------------
   typedef struct {
      bit          v;
      bit          r;
      logic [15:0] res;
      int          exp_count;
      bit          exp_ready;
      bit          exp_valid;
      logic [15:0] exp_res;
      logic [3:0]  exp_flags;
   } vec_t;

   vec_t vt[9];

   logic [N-1:0] hold_res;
   logic [3:0]   hold_flags;
   logic [2:0]   hold_op;

   initial begin
      vt[0] = '{1, 0, 16'h8001, 1, 1, 1, 16'h8001, 4'b0100};
      vt[1] = '{1, 0, 16'h0002, 2, 1, 1, 16'h8001, 4'b0100};
      vt[2] = '{1, 0, 16'h0003, 3, 1, 1, 16'h8001, 4'b0100};
      vt[3] = '{1, 0, 16'h0004, 4, 0, 1, 16'h8001, 4'b0100};
      vt[4] = '{1, 0, 16'h0005, 4, 0, 1, 16'h8001, 4'b0100};
      vt[5] = '{0, 1, 16'h0000, 3, 1, 1, 16'h0002, 4'b0000};
      vt[6] = '{0, 1, 16'h0000, 2, 1, 1, 16'h0003, 4'b0000};
      vt[7] = '{0, 1, 16'h0000, 1, 1, 1, 16'h0004, 4'b0000};
      vt[8] = '{0, 1, 16'h0000, 0, 1, 0, 16'h0000, 4'b0000};

      m_sticky = 0;
      rst_n_i  = 1'b0;
      drive(0, 0, 16'h0, 0, 0, 3'd0, 0);
      repeat (2) @(negedge clk_i);
      rst_n_i = 1'b1;
      #1;
      // Reset state
      chk("rst_count", 32'(count_o), 0);
      chk("rst_valid", 32'(valid_o), 0);
      chk("rst_ready", 32'(ready_o), 1);
      chk("rst_sticky", 32'(sticky_ovf_o), 0);
      chk("rst_result", 32'(result_o), 0);
      chk("rst_flags", 32'(flags_o), 0);
      @(negedge clk_i);

      // Zero result held under backpressure
      drive(1, 0, 16'h0000, 0, 1, 3'd5, 0);
      step();
      drive(0, 0, 16'h0, 0, 0, 3'd0, 0);
      chk("zero_valid", 32'(valid_o), 1);
      chk("zero_flags", 32'(flags_o), 32'(4'b1001));
      hold_res = result_o; hold_flags = flags_o; hold_op = opcode_o;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hold_result", 32'(result_o), 32'(hold_res));
         chk("hold_flags", 32'(flags_o), 32'(hold_flags));
         chk("hold_opcode", 32'(opcode_o), 32'(hold_op));
      end
      drain();

      // Table: fill to full, dropped 5th push, ordered drain
      for (int i = 0; i < 9; i++) begin
         drive(vt[i].v, vt[i].r, vt[i].res, 0, 0, 3'(i), 0);
         step();
         chk("tbl_count", 32'(count_o), 32'(vt[i].exp_count));
         chk("tbl_ready", 32'(ready_o), 32'(vt[i].exp_ready));
         chk("tbl_valid", 32'(valid_o), 32'(vt[i].exp_valid));
         if (vt[i].exp_valid) begin
            chk("tbl_result", 32'(result_o), 32'(vt[i].exp_res));
            chk("tbl_flags", 32'(flags_o), 32'(vt[i].exp_flags));
         end
      end

      // Full with simultaneous push and pop: only the pop happens
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, 0, 16'h0011 + 16'(i), 0, 0, 3'd1, 0);
         step();
      end
      drive(1, 1, 16'h0099, 0, 0, 3'd7, 0);
      step();
      chk("full_pp_count", 32'(count_o), 3);
      chk("full_pp_head", 32'(result_o), 32'h0012);
      drive(1, 0, 16'h0055, 0, 0, 3'd2, 0);
      step();
      chk("after_full_push", 32'(count_o), 4);
      drain();

      // Steady push+pop at count 2 with pointer wrap
      drive(1, 0, 16'h0100, 0, 0, 3'd0, 0); step();
      drive(1, 0, 16'h0101, 0, 0, 3'd1, 0); step();
      for (int i = 0; i < 10; i++) begin
         drive(1, 1, 16'h0102 + 16'(i), 0, 1, 3'(i), 0);
         step();
         chk("steady_count", 32'(count_o), 2);
         chk("steady_head", 32'(result_o), 32'h0101 + 32'(i));
      end
      drain();

      // Sticky overflow: set wins over clear, clear alone, refused push
      drive(1, 0, 16'h7fff, 1, 0, 3'd3, 1); step();
      chk("sticky_set_wins", 32'(sticky_ovf_o), 1);
      drive(0, 0, 16'h0, 0, 0, 3'd0, 1); step();
      chk("sticky_clear", 32'(sticky_ovf_o), 0);
      drive(1, 0, 16'h0001, 0, 0, 3'd0, 0);
      for (int i = 0; i < DEPTH - 1; i++) step();
      chk("sticky_full", 32'(ready_o), 0);
      drive(1, 0, 16'h0bad, 1, 0, 3'd4, 0); step();
      chk("sticky_refused", 32'(sticky_ovf_o), 0);

      // Asynchronous reset mid-operation at count 3
      drive(0, 1, 16'h0, 0, 0, 3'd0, 0); step();
      drive(0, 0, 16'h0, 0, 0, 3'd0, 0);
      chk("pre_rst_count", 32'(count_o), 3);
      #2 rst_n_i = 1'b0;
      #1;
      chk("async_valid", 32'(valid_o), 0);
      chk("async_count", 32'(count_o), 0);
      chk("async_ready", 32'(ready_o), 1);
      mq.delete();
      m_sticky = 0;
      @(negedge clk_i);
      #2 rst_n_i = 1'b1;
      #1;
      chk("post_rst_result", 32'(result_o), 0);
      chk("post_rst_flags", 32'(flags_o), 0);
      chk("post_rst_opcode", 32'(opcode_o), 0);
      drive(1, 0, 16'h00aa, 0, 0, 3'd6, 0);
      step();
      chk("first_push_after_rst", 32'(count_o), 1);
      chk("no_stale_head", 32'(result_o), 32'h00aa);
      drain();

      // Randomized phase against the reference model
      for (int i = 0; i < 400; i++) begin
         logic [N-1:0] r;
         r = 16'($urandom);
         case ($urandom_range(0, 3))
            0: r = '0;
            1: r[N-1] = 1'b1;
            default: ;
         endcase
         drive(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 2) != 0), r,
               bit'($urandom_range(0, 7) == 0), bit'($urandom_range(0, 1)),
               3'($urandom_range(0, 7)), bit'($urandom_range(0, 5) == 0));
         step();
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
